dmem_loader: RTL and testbench
==============================

DMEM_LOADER -- requirements
Module: dmem_loader

Interface
REQ-001 SIZE, 16384, data memory size in bytes; a multiple of 4.
REQ-002 BASE, 32'h0, first byte address written by the load phase; word-aligned.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-006 inValid  input  1  inByte holds a valid byte.
REQ-007 inByte  input  [0:7]  stream byte, in big-endian order.
REQ-008 inLast  input  1  qualifies the final byte of the stream.
REQ-009 inReady  output  1  loader accepts a byte this cycle.
REQ-010 addr  output  [0:31]  dmem byte address.
REQ-011 wData  output  [0:31]  dmem write data.
REQ-012 writeEnable  output  1  dmem write strobe, sampled by dmem on rising clk.
REQ-013 dsize  output  [0:1]  access size: 2'b00 byte, 2'b01 halfword, 2'b11 word; always 2'b11 from this block.
REQ-014 busy  output  1  high in CLEAR, LOAD and WRITE.
REQ-015 done  output  1  high in DONE.
REQ-016 error  output  1  overflow flag; valid while done=1.
REQ-017 wordCount  output  [0:31]  number of words written during the load phase.

Function
REQ-018 States: IDLE, CLEAR, LOAD, WRITE, DONE.
REQ-019 IDLE or DONE with start=1 -> CLEAR (macro on) or LOAD (macro off); the transition clears wordCount, error and the byte index.
REQ-020 CLEAR: one word write per cycle, addr 0,4,...,SIZE-4, wData=0, writeEnable=1; SIZE/4 cycles total; then LOAD.
REQ-021 LOAD: inReady=1 and writeEnable=0; a byte transfers on a rising edge with inValid&inReady.
REQ-022 Byte k (k=0..3) of a word is placed in wData[8k:8k+7], so byte 0 is the MSB.
REQ-023 The 4th accepted byte, or any byte with inLast=1, moves the block to WRITE on the next cycle.
REQ-024 For a partial word, unfilled low bytes of wData are zero.
REQ-025 WRITE: exactly one cycle, writeEnable=1, addr=BASE+4*wordCount, inReady=0; wordCount increments on the exit edge.
REQ-026 WRITE exit goes to DONE if the word held inLast, else to LOAD.
REQ-027 Overflow: if BASE+4*wordCount is >= SIZE on entry to WRITE, writeEnable stays 0, error is set and the next state is DONE.
REQ-028 start is ignored while busy=1.
REQ-029 inValid is ignored outside LOAD; the sender holds the byte until inReady.
REQ-030 In DONE: writeEnable=0, inReady=0, and done stays high until the next start or reset.
REQ-031 addr and wData are don't-care when writeEnable=0, but they must not toggle X.

Reset
REQ-032 rst_n=0 forces IDLE immediately, independent of clk, including in the middle of CLEAR, LOAD or WRITE.
REQ-033 Reset values: inReady=0, addr=0, wData=0, writeEnable=0, dsize=2'b11, busy=0, done=0, error=0, wordCount=0.
REQ-034 A write in progress when reset asserts is abandoned; writeEnable falls asynchronously.

Configuration
REQ-035 Macro DMEM_LOADER_CLEAR_EN: when defined, the CLEAR state and its address counter are built and start enters CLEAR.
REQ-036 Without DMEM_LOADER_CLEAR_EN, the CLEAR state is absent, start enters LOAD directly and memory contents are left untouched.

Verification
REQ-037 Macro on, SIZE=64: start -> 16 consecutive cycles with writeEnable=1, addr 0..60 step 4, wData=0; then inReady=1.
REQ-038 Stream bytes 8'h12,8'h34,8'h56,8'h78 with inLast on the last byte -> one write with addr=BASE and wData=32'h12345678, then done=1, wordCount=1, error=0.
REQ-039 Stream bytes AA,BB,CC,DD,EE with inLast on EE -> writes 32'hAABBCCDD at BASE and 32'hEE000000 at BASE+4; wordCount=2.
REQ-040 SIZE=16, BASE=0, macro off, 20 bytes -> 4 writes, then error=1 and done=1 with no 5th write.
REQ-041 Assert rst_n=0 on the cycle after the 2nd byte -> all outputs at reset values without waiting for a clk edge; a new start reloads from wordCount=0.
REQ-042 Pulse start while busy=1, and hold inValid high in DONE -> no state change and no writeEnable.

Source files
------------

// File: rtl/dmem_loader.sv
// Streams big-endian bytes into word writes for a data memory starting at BASE.
// Define DMEM_LOADER_CLEAR_EN to zero the whole memory before each load.
module dmem_loader #(
   parameter int unsigned SIZE = 16384,
   parameter logic [31:0] BASE = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        inValid,
   input  logic [0:7]  inByte,
   input  logic        inLast,
   output logic        inReady,
   output logic [0:31] addr,
   output logic [0:31] wData,
   output logic        writeEnable,
   output logic [0:1]  dsize,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [0:31] wordCount
);

`ifdef DMEM_LOADER_CLEAR_EN
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WRITE, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

   state_t      state;
   state_t      nextState;
   logic [1:0]  byteIdx;
   logic [31:0] wordBuf;
   logic        lastWord;
   logic [31:0] writeAddr;
   logic        overflow;
   logic        accept;
   logic        launch;
`ifdef DMEM_LOADER_CLEAR_EN
   logic [31:0] clearAddr;
`endif

   assign accept    = (state == LOAD) && inValid;
   assign launch    = start && ((state == IDLE) || (state == DONE));
   assign writeAddr = BASE + (wordCount << 2);
   assign overflow  = writeAddr >= 32'(SIZE);
   assign dsize     = 2'b11;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Word assembly, word counter and overflow flag; a new load starts from a clean word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wordCount <= 32'd0;
         error     <= 1'b0;
         byteIdx   <= 2'd0;
         wordBuf   <= 32'd0;
         lastWord  <= 1'b0;
`ifdef DMEM_LOADER_CLEAR_EN
         clearAddr <= 32'd0;
`endif
      end else if (launch) begin
         wordCount <= 32'd0;
         error     <= 1'b0;
         byteIdx   <= 2'd0;
         wordBuf   <= 32'd0;
         lastWord  <= 1'b0;
`ifdef DMEM_LOADER_CLEAR_EN
         clearAddr <= 32'd0;
      end else if (state == CLEAR) begin
         clearAddr <= clearAddr + 32'd4;
`endif
      end else if (accept) begin
         case (byteIdx)
            2'd0:    wordBuf[31:24] <= inByte;
            2'd1:    wordBuf[23:16] <= inByte;
            2'd2:    wordBuf[15:8]  <= inByte;
            default: wordBuf[7:0]   <= inByte;
         endcase
         byteIdx  <= byteIdx + 2'd1;
         lastWord <= inLast;
      end else if (state == WRITE) begin
         byteIdx <= 2'd0;
         wordBuf <= 32'd0;
         if (overflow) begin
            error <= 1'b1;
         end else begin
            wordCount <= wordCount + 32'd1;
         end
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
`ifdef DMEM_LOADER_CLEAR_EN
               nextState = CLEAR;
`else
               nextState = LOAD;
`endif
            end
         end
`ifdef DMEM_LOADER_CLEAR_EN
         CLEAR: begin
            if (clearAddr == 32'(SIZE - 4)) begin
               nextState = LOAD;
            end
         end
`endif
         LOAD: begin
            if (accept && ((byteIdx == 2'd3) || inLast)) begin
               nextState = WRITE;
            end
         end
         WRITE: begin
            nextState = (overflow || lastWord) ? DONE : LOAD;
         end
         default: nextState = IDLE;
      endcase
   end

   // Outputs decode from state only, so reset drops writeEnable without a clock edge.
   always_comb begin
      inReady     = 1'b0;
      addr        = 32'd0;
      wData       = 32'd0;
      writeEnable = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
`ifdef DMEM_LOADER_CLEAR_EN
         CLEAR: begin
            busy        = 1'b1;
            writeEnable = 1'b1;
            addr        = clearAddr;
         end
`endif
         LOAD: begin
            busy    = 1'b1;
            inReady = 1'b1;
         end
         WRITE: begin
            busy        = 1'b1;
            addr        = writeAddr;
            wData       = wordBuf;
            writeEnable = !overflow;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader: directed table, corner sequences, random streams.
// Build with DMEM_LOADER_CLEAR_EN defined to also check the clear phase.
module tb_dmem_loader;

   localparam int          SIZE = 16;
   localparam logic [31:0] BASE = 32'h0;
   localparam int          CAP  = (SIZE - int'(BASE)) / 4;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        inValid;
   logic [7:0]  inByte;
   logic        inLast;
   logic        inReady;
   logic [31:0] addr;
   logic [31:0] wData;
   logic        writeEnable;
   logic [1:0]  dsize;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] wordCount;

   int total = 0;
   int bad   = 0;
   logic [63:0] wq[$];

   typedef struct packed {
      logic [4:0]   n;
      logic [159:0] stream;
      logic [2:0]   expWc;
      logic         expErr;
      logic [31:0]  w0;
      logic [31:0]  w1;
   } vec_t;

   dmem_loader #(.SIZE(SIZE), .BASE(BASE)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .inValid(inValid),
      .inByte(inByte),
      .inLast(inLast),
      .inReady(inReady),
      .addr(addr),
      .wData(wData),
      .writeEnable(writeEnable),
      .dsize(dsize),
      .busy(busy),
      .done(done),
      .error(error),
      .wordCount(wordCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory-side monitor: every cycle with writeEnable high is one word write.
   always @(negedge clk) begin
      if (writeEnable === 1'b1) wq.push_back({addr, wData});
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput($sformatf("%s.inReady", tag), inReady, 0);
      checkOutput($sformatf("%s.addr", tag), addr, 0);
      checkOutput($sformatf("%s.wData", tag), wData, 0);
      checkOutput($sformatf("%s.writeEnable", tag), writeEnable, 0);
      checkOutput($sformatf("%s.dsize", tag), dsize, 3);
      checkOutput($sformatf("%s.busy", tag), busy, 0);
      checkOutput($sformatf("%s.done", tag), done, 0);
      checkOutput($sformatf("%s.error", tag), error, 0);
      checkOutput($sformatf("%s.wordCount", tag), wordCount, 0);
   endtask

   task automatic doStart();
      int g;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      g = 0;
      while (!inReady && g < 200) begin
         @(negedge clk);
         g++;
      end
      checkOutput("startReady", inReady, 1);
      wq.delete();
   endtask

   task automatic sendByte(input logic [7:0] b, input logic l);
      int g;
      inValid = 1'b1;
      inByte  = b;
      inLast  = l;
      g = 0;
      while (!inReady && !done && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (inReady) @(negedge clk);
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] q[$]);
      for (int i = 0; i < q.size(); i++) begin
         if (done) break;
         sendByte(q[i], i == q.size() - 1);
      end
   endtask

   task automatic waitDone();
      int g;
      g = 0;
      while (!done && g < 200) begin
         @(negedge clk);
         g++;
      end
   endtask

   // Reference model: bytes pack big-endian into words, zero padded, capped at memory capacity.
   task automatic checkResult(input string tag, input logic [7:0] q[$]);
      int nw;
      int ew;
      logic [31:0] word;
      logic [7:0]  b;
      nw = (q.size() + 3) / 4;
      ew = (nw > CAP) ? CAP : nw;
      checkOutput($sformatf("%s.done", tag), done, 1);
      checkOutput($sformatf("%s.error", tag), error, (nw > CAP) ? 1 : 0);
      checkOutput($sformatf("%s.wordCount", tag), wordCount, ew);
      checkOutput($sformatf("%s.writes", tag), wq.size(), ew);
      for (int w = 0; w < ew && w < wq.size(); w++) begin
         word = 32'd0;
         for (int k = 0; k < 4; k++) begin
            b = (4 * w + k < q.size()) ? q[4 * w + k] : 8'h00;
            word = {word[23:0], b};
         end
         checkOutput($sformatf("%s.addr%0d", tag, w), wq[w][63:32], BASE + 4 * w);
         checkOutput($sformatf("%s.data%0d", tag, w), wq[w][31:0], word);
      end
   endtask

   initial begin
      vec_t vecs[7];
      logic [7:0] q[$];
      int n;
      int wb;

      vecs[0] = '{5'd4,  {32'h12345678, 128'h0},   3'd1, 1'b0, 32'h12345678, 32'h0};
      vecs[1] = '{5'd5,  {40'hAABBCCDDEE, 120'h0}, 3'd2, 1'b0, 32'hAABBCCDD, 32'hEE000000};
      vecs[2] = '{5'd1,  {8'h5A, 152'h0},          3'd1, 1'b0, 32'h5A000000, 32'h0};
      vecs[3] = '{5'd6,  {48'h010203040506, 112'h0}, 3'd2, 1'b0, 32'h01020304, 32'h05060000};
      vecs[4] = '{5'd16, {128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h0},
                  3'd4, 1'b0, 32'h00112233, 32'h44556677};
      vecs[5] = '{5'd17, {128'h00112233_44556677_8899AABB_CCDDEEFF, 8'h99, 24'h0},
                  3'd4, 1'b1, 32'h00112233, 32'h44556677};
      vecs[6] = '{5'd20, {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 32'h10111213},
                  3'd4, 1'b1, 32'h00010203, 32'h04050607};

      rst_n   = 1'b0;
      start   = 1'b0;
      inValid = 1'b0;
      inByte  = 8'h00;
      inLast  = 1'b0;
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;
      @(negedge clk);

`ifdef DMEM_LOADER_CLEAR_EN
      wq.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!inReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("clear.ready", inReady, 1);
      checkOutput("clear.writes", wq.size(), SIZE / 4);
      for (int i = 0; i < wq.size(); i++) begin
         checkOutput($sformatf("clear.addr%0d", i), wq[i][63:32], 4 * i);
         checkOutput($sformatf("clear.data%0d", i), wq[i][31:0], 0);
      end
      q.delete();
      q.push_back(8'h01);
      applyStimulus(q);
      waitDone();
`endif

      for (int v = 0; v < 7; v++) begin
         q.delete();
         for (int i = 0; i < int'(vecs[v].n); i++) q.push_back(vecs[v].stream[159 - 8 * i -: 8]);
         doStart();
         applyStimulus(q);
         waitDone();
         wb = int'(vecs[v].expWc);
         checkOutput($sformatf("vec%0d.done", v), done, 1);
         checkOutput($sformatf("vec%0d.error", v), error, vecs[v].expErr);
         checkOutput($sformatf("vec%0d.wordCount", v), wordCount, vecs[v].expWc);
         checkOutput($sformatf("vec%0d.writes", v), wq.size(), wb);
         checkOutput($sformatf("vec%0d.inReady", v), inReady, 0);
         if (wq.size() >= 1) begin
            checkOutput($sformatf("vec%0d.addr0", v), wq[0][63:32], BASE);
            checkOutput($sformatf("vec%0d.w0", v), wq[0][31:0], vecs[v].w0);
         end
         if (wb >= 2 && wq.size() >= 2) begin
            checkOutput($sformatf("vec%0d.addr1", v), wq[1][63:32], BASE + 4);
            checkOutput($sformatf("vec%0d.w1", v), wq[1][31:0], vecs[v].w1);
         end
         if (wq.size() == wb) begin
            checkOutput($sformatf("vec%0d.lastAddr", v), wq[wb - 1][63:32], BASE + 4 * (wb - 1));
         end
      end

      // start while loading must not restart the word; inValid in DONE must not write.
      doStart();
      sendByte(8'hC1, 1'b0);
      sendByte(8'hC2, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busyStart.busy", busy, 1);
      sendByte(8'hC3, 1'b0);
      sendByte(8'hC4, 1'b1);
      waitDone();
      checkOutput("busyStart.wordCount", wordCount, 1);
      checkOutput("busyStart.writes", wq.size(), 1);
      if (wq.size() >= 1) checkOutput("busyStart.data", wq[0][31:0], 32'hC1C2C3C4);
      inValid = 1'b1;
      inByte  = 8'hFF;
      repeat (5) @(negedge clk);
      checkOutput("doneHold.writes", wq.size(), 1);
      checkOutput("doneHold.done", done, 1);
      checkOutput("doneHold.inReady", inReady, 0);
      checkOutput("doneHold.wordCount", wordCount, 1);
      inValid = 1'b0;

      // Asynchronous reset in the middle of a word, then a clean reload.
      doStart();
      sendByte(8'h11, 1'b0);
      sendByte(8'h22, 1'b0);
      #2 rst_n = 1'b0;
      #1 checkResetValues("midLoadReset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q.delete();
      q.push_back(8'h33); q.push_back(8'h44); q.push_back(8'h55); q.push_back(8'h66);
      doStart();
      applyStimulus(q);
      waitDone();
      checkResult("reload", q);

      // Asynchronous reset while a word write is on the bus.
      doStart();
      sendByte(8'hA1, 1'b0);
      sendByte(8'hA2, 1'b0);
      sendByte(8'hA3, 1'b0);
      sendByte(8'hA4, 1'b0);
      checkOutput("writeReset.weBefore", writeEnable, 1);
      #2 rst_n = 1'b0;
      #1 checkResetValues("writeReset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int r = 0; r < 12; r++) begin
         q.delete();
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         doStart();
         applyStimulus(q);
         waitDone();
         checkResult($sformatf("rand%0d", r), q);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
